// File: rtl/cdr_pkg.sv
// Shared definitions for the CDR NCO: state encoding, default phase width
// and the unsigned FCW clamp.
package cdr_pkg;

  localparam int CDR_PHASE_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    HOLDOVER = 2'd2
  } state_t;

  // raw carries two guard bits so negative and overflowing sums clamp correctly
  function automatic logic [CDR_PHASE_W-1:0] clamp_fcw(
    input logic signed [CDR_PHASE_W+1:0] raw,
    input logic        [CDR_PHASE_W-1:0] lo,
    input logic        [CDR_PHASE_W-1:0] hi
  );
    if (raw < $signed({2'b00, lo}))
      return lo;
    else if (raw > $signed({2'b00, hi}))
      return hi;
    else
      return raw[CDR_PHASE_W-1:0];
  endfunction

endpackage

// File: rtl/cdr_nco_phase_acc.sv
// Phase accumulator with registered wrap (sample) and MSB-rise (edge) strobes.
// Optional CDR_NCO_DITHER_EN adds LFSR dither to the accumulator sum only.
module cdr_nco_phase_acc
  import cdr_pkg::*;
#(
  parameter int PHASE_W = CDR_PHASE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] fcw,
  output logic [PHASE_W-1:0] phase,
  output logic               sample_stb,
  output logic               edge_stb
);

  logic [PHASE_W:0] sum;

`ifdef CDR_NCO_DITHER_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= 16'hACE1;
    else
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign sum = {1'b0, phase} + {1'b0, fcw} + {{(PHASE_W-3){1'b0}}, lfsr[3:0]};
`else
  assign sum = {1'b0, phase} + {1'b0, fcw};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= '0;
      sample_stb <= 1'b0;
      edge_stb   <= 1'b0;
    end else begin
      phase      <= sum[PHASE_W-1:0];
      sample_stb <= sum[PHASE_W];
      edge_stb   <= ~phase[PHASE_W-1] & sum[PHASE_W-1];
    end
  end

endmodule

// File: rtl/cdr_nco.sv
// CDR NCO top: FCW scaling/clamping and IDLE/TRACK/HOLDOVER control around the
// phase accumulator. Optional dither is enabled with CDR_NCO_DITHER_EN.
module cdr_nco
  import cdr_pkg::*;
#(
  parameter int                 PHASE_W      = CDR_PHASE_W,
  parameter logic [PHASE_W-1:0] NOM_FCW      = 32'h1000_0000,
  parameter int unsigned        GAIN_SH      = 8,
  parameter logic [PHASE_W-1:0] FCW_MIN      = 32'h0800_0000,
  parameter logic [PHASE_W-1:0] FCW_MAX      = 32'h2000_0000,
  parameter int unsigned        HOLD_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic signed [31:0] v_ctrl,
  input  logic               ctrl_valid,
  output logic [PHASE_W-1:0] phase,
  output logic [PHASE_W-1:0] fcw,
  output logic               sample_stb,
  output logic               edge_stb,
  output logic [1:0]         state,
  output logic               holdover
);

  state_t                    cur_state;
  logic [15:0]               gap_cnt;
  logic signed [31:0]        v_shift;
  logic signed [PHASE_W+1:0] fcw_raw;
  logic [PHASE_W-1:0]        fcw_clamped;
  logic                      ctrl_ok;

  assign v_shift     = v_ctrl >>> GAIN_SH;
  assign fcw_raw     = $signed({2'b00, NOM_FCW}) +
                       $signed({{(PHASE_W-30){v_shift[31]}}, v_shift});
  assign fcw_clamped = clamp_fcw(fcw_raw, FCW_MIN, FCW_MAX);

  // An unknown control word in simulation is treated as no update at all
`ifdef SYNTHESIS
  assign ctrl_ok = ctrl_valid;
`else
  assign ctrl_ok = ctrl_valid && !$isunknown(v_ctrl);
`endif

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cur_state <= IDLE;
      fcw       <= NOM_FCW;
      gap_cnt   <= '0;
      holdover  <= 1'b0;
    end else begin
      case (cur_state)
        IDLE: begin
          gap_cnt  <= '0;
          holdover <= 1'b0;
          if (ctrl_ok) begin
            cur_state <= TRACK;
            fcw       <= fcw_clamped;
          end else begin
            fcw <= NOM_FCW;
          end
        end
        TRACK: begin
          // a fresh update wins over an expiring timeout
          if (ctrl_ok) begin
            fcw     <= fcw_clamped;
            gap_cnt <= '0;
          end else if (gap_cnt == 16'(HOLD_TIMEOUT - 1)) begin
            cur_state <= HOLDOVER;
            holdover  <= 1'b1;
            gap_cnt   <= '0;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        HOLDOVER: begin
          if (ctrl_ok) begin
            cur_state <= TRACK;
            holdover  <= 1'b0;
            fcw       <= fcw_clamped;
            gap_cnt   <= '0;
          end
        end
        default: begin
          cur_state <= IDLE;
          fcw       <= NOM_FCW;
          gap_cnt   <= '0;
          holdover  <= 1'b0;
        end
      endcase
    end
  end

  assign state = cur_state;

  cdr_nco_phase_acc #(
    .PHASE_W(PHASE_W)
  ) u_phase_acc (
    .clk       (clk),
    .rst       (rst),
    .fcw       (fcw),
    .phase     (phase),
    .sample_stb(sample_stb),
    .edge_stb  (edge_stb)
  );

endmodule

// File: tb/tb_cdr_nco.sv
// Bench for cdr_nco: default-gain instance plus a unity-gain instance that can
// reach the FCW clamps, both checked every cycle against a behavioural model.
module tb_cdr_nco;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic signed [31:0] v_ctrl = '0;
  logic               ctrl_valid = 1'b0;

  logic [31:0] phase_o [2];
  logic [31:0] fcw_o   [2];
  logic        samp_o  [2];
  logic        edge_o  [2];
  logic [1:0]  state_o [2];
  logic        hold_o  [2];

  int n_vec = 0;
  int n_err = 0;

  localparam longint TWO32 = 64'd4294967296;
  localparam longint TWO31 = 64'd2147483648;
  localparam longint NOM   = 64'd268435456;
  localparam longint FMIN  = 64'd134217728;
  localparam longint FMAX  = 64'd536870912;
  int sh_tab [2] = '{8, 0};

  always #5 clk = ~clk;

  cdr_nco u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .v_ctrl(v_ctrl), .ctrl_valid(ctrl_valid),
    .phase(phase_o[0]), .fcw(fcw_o[0]), .sample_stb(samp_o[0]), .edge_stb(edge_o[0]),
    .state(state_o[0]), .holdover(hold_o[0])
  );

  cdr_nco #(.GAIN_SH(0)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .v_ctrl(v_ctrl), .ctrl_valid(ctrl_valid),
    .phase(phase_o[1]), .fcw(fcw_o[1]), .sample_stb(samp_o[1]), .edge_stb(edge_o[1]),
    .state(state_o[1]), .holdover(hold_o[1])
  );

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; return just after the
  // rising edge that consumed them.
  task automatic applyStimulus(input logic r, input logic en, input logic cv,
                               input logic [31:0] vc);
    @(negedge clk);
    rst        = r;
    enable     = en;
    ctrl_valid = cv;
    v_ctrl     = vc;
    @(posedge clk);
    #2;
  endtask

  // Behavioural model: frequency word, wrapping phase and a count of
  // consecutive cycles without an update while tracking.
  longint m_phase [2];
  longint m_fcw   [2];
  bit     m_samp  [2];
  bit     m_edge  [2];
  int     m_state;
  int     m_gap;
  bit     m_live = 1'b0;

  function automatic longint model_fcw(input logic signed [31:0] v, input int sh);
    longint raw;
    raw = NOM + (longint'(v) >>> sh);
    if (raw < FMIN) return FMIN;
    if (raw > FMAX) return FMAX;
    return raw;
  endfunction

  always @(posedge clk) begin
    logic r, en, cv;
    logic signed [31:0] vc;
    r = rst; en = enable; cv = ctrl_valid; vc = v_ctrl;
    if (r) begin
      m_live  = 1'b1;
      m_state = 0;
      m_gap   = 0;
      for (int k = 0; k < 2; k++) begin
        m_phase[k] = 0; m_fcw[k] = NOM; m_samp[k] = 0; m_edge[k] = 0;
      end
    end else if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        longint nxt;
        nxt        = m_phase[k] + m_fcw[k];
        m_samp[k]  = (nxt >= TWO32);
        nxt        = nxt % TWO32;
        m_edge[k]  = (m_phase[k] < TWO31) && (nxt >= TWO31);
        m_phase[k] = nxt;
      end
      if (!en) begin
        m_state = 0; m_gap = 0;
        for (int k = 0; k < 2; k++) m_fcw[k] = NOM;
      end else if (cv) begin
        m_state = 1; m_gap = 0;
        for (int k = 0; k < 2; k++) m_fcw[k] = model_fcw(vc, sh_tab[k]);
      end else if (m_state == 1) begin
        m_gap++;
        if (m_gap == 1024) m_state = 2;
      end
    end
    #1;
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("phase%0d", k), longint'(phase_o[k]), m_phase[k]);
        checkOutput($sformatf("fcw%0d", k), longint'(fcw_o[k]), m_fcw[k]);
        checkOutput($sformatf("sample_stb%0d", k), longint'(samp_o[k]), longint'(m_samp[k]));
        checkOutput($sformatf("edge_stb%0d", k), longint'(edge_o[k]), longint'(m_edge[k]));
        checkOutput($sformatf("state%0d", k), longint'(state_o[k]), longint'(m_state));
        checkOutput($sformatf("holdover%0d", k), longint'(hold_o[k]), longint'(m_state == 2));
      end
    end
  end

  task automatic check_reset_values();
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_phase", longint'(phase_o[k]), 0);
      checkOutput("rst_fcw", longint'(fcw_o[k]), 64'h1000_0000);
      checkOutput("rst_sample", longint'(samp_o[k]), 0);
      checkOutput("rst_edge", longint'(edge_o[k]), 0);
      checkOutput("rst_state", longint'(state_o[k]), 0);
      checkOutput("rst_holdover", longint'(hold_o[k]), 0);
    end
  endtask

  initial begin
    int first_samp, first_edge, n_samp, last;
    logic [31:0] p_before, f_before;

    $display("[TB] cdr_nco bench start");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    check_reset_values();

    // Freerun at nominal: wrap every 16 cycles, MSB rise 8 cycles earlier
    first_samp = -1; first_edge = -1; n_samp = 0;
    for (int i = 1; i <= 64; i++) begin
      applyStimulus(0, 1, 0, 0);
      if (samp_o[0]) begin
        n_samp++;
        if (first_samp < 0) first_samp = i;
      end
      if (edge_o[0] && first_edge < 0) first_edge = i;
    end
    checkOutput("first_sample_cycle", first_samp, 16);
    checkOutput("first_edge_cycle", first_edge, 8);
    checkOutput("idle_sample_count", n_samp, 4);
    checkOutput("idle_state", longint'(state_o[0]), 0);

    applyStimulus(0, 1, 1, 32'sh0100_0000);
    checkOutput("track_entry_state", longint'(state_o[0]), 1);
    checkOutput("track_entry_fcw", longint'(fcw_o[0]), 64'h1001_0000);
    checkOutput("track_entry_fcw_unity", longint'(fcw_o[1]), 64'h1100_0000);

    for (int i = 0; i < 1023; i++) applyStimulus(0, 1, 0, 0);
    checkOutput("pre_timeout_state", longint'(state_o[0]), 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("timeout_state", longint'(state_o[0]), 2);
    checkOutput("timeout_holdover", longint'(hold_o[0]), 1);
    checkOutput("timeout_fcw_held", longint'(fcw_o[0]), 64'h1001_0000);

    // Clamp boundaries on the unity-gain instance
    applyStimulus(0, 1, 1, 32'sh7FFF_FFFF);
    checkOutput("exit_holdover_state", longint'(state_o[0]), 1);
    checkOutput("max_in_fcw", longint'(fcw_o[0]), 64'h107F_FFFF);
    checkOutput("clamp_max_fcw", longint'(fcw_o[1]), 64'h2000_0000);
    last = -1; n_samp = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 1, 0, 0);
      if (samp_o[1]) begin
        if (last >= 0) checkOutput("period_at_max", i - last, 8);
        last = i; n_samp++;
      end
    end
    checkOutput("wraps_at_max", n_samp, 5);

    applyStimulus(0, 1, 1, 32'h8000_0000);
    checkOutput("min_in_fcw", longint'(fcw_o[0]), 64'h0F80_0000);
    checkOutput("clamp_min_fcw", longint'(fcw_o[1]), 64'h0800_0000);
    last = -1; n_samp = 0;
    for (int i = 0; i < 96; i++) begin
      applyStimulus(0, 1, 0, 0);
      if (samp_o[1]) begin
        if (last >= 0) checkOutput("period_at_min", i - last, 32);
        last = i; n_samp++;
      end
    end
    checkOutput("wraps_at_min", n_samp, 3);

    // Update arriving exactly on the expiry cycle keeps TRACK
    applyStimulus(0, 1, 1, 0);
    for (int i = 0; i < 1023; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 32'sh0000_1000);
    checkOutput("expiry_race_state", longint'(state_o[0]), 1);
    checkOutput("expiry_race_fcw", longint'(fcw_o[0]), 64'h1000_0010);
    applyStimulus(0, 1, 0, 0);
    checkOutput("expiry_race_after", longint'(state_o[0]), 1);

    // Disable wins over a simultaneous update; phase keeps running
    p_before = phase_o[0];
    f_before = fcw_o[0];
    applyStimulus(0, 0, 1, 32'sh0100_0000);
    checkOutput("disable_state", longint'(state_o[0]), 0);
    checkOutput("disable_fcw", longint'(fcw_o[0]), 64'h1000_0000);
    checkOutput("disable_phase", longint'(phase_o[0]), longint'(32'(p_before + f_before)));

    applyStimulus(0, 1, 1, 32'sh0100_0000);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 1, 32'sh0100_0000);
    check_reset_values();
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cdr_nco.md
Name: cdr_nco

Overview:
- Digitally controlled oscillator stage directly downstream of the CDR loop filter.
- Converts the filter's signed 32-bit control word into a clamped frequency control word (FCW) and runs a phase accumulator.
- Emits sample and edge strobes that clock the data/edge samplers feeding the phase detector.
- Includes a freerun/track/holdover state machine so the loop survives gaps in control updates.

Parameters:
- PHASE_W, 32: phase accumulator and FCW width (unsigned).
- NOM_FCW, 32'h1000_0000: nominal FCW (centre frequency, 1/16 of clk).
- GAIN_SH, 8: arithmetic right shift applied to v_ctrl before adding to NOM_FCW.
- FCW_MIN, 32'h0800_0000: lower FCW clamp, unsigned.
- FCW_MAX, 32'h2000_0000: upper FCW clamp, unsigned; must be < 2^(PHASE_W-1).
- HOLD_TIMEOUT, 1024: cycles without ctrl_valid before TRACK drops to HOLDOVER; range 1..65535.

Ports:
- clk, input, 1: single clock for the block.
- rst, input, 1: synchronous, active-high reset.
- enable, input, 1: 0 forces IDLE (freerun at NOM_FCW).
- v_ctrl, input, 32 signed: control word from the loop filter.
- ctrl_valid, input, 1: v_ctrl qualifies this cycle.
- phase, output, PHASE_W: accumulator value.
- fcw, output, PHASE_W: FCW currently applied.
- sample_stb, output, 1: one-cycle pulse on accumulator wrap (data sample point).
- edge_stb, output, 1: one-cycle pulse when phase MSB goes 0->1 (edge sample point).
- state, output, 2: 0=IDLE, 1=TRACK, 2=HOLDOVER.
- holdover, output, 1: high while in HOLDOVER.

Behaviour:
- Reset: synchronous, at a clk edge with rst=1. Values after reset:
  - phase=0, fcw=NOM_FCW, sample_stb=0, edge_stb=0.
  - state=IDLE, holdover=0, timeout counter=0.
  - Reset mid-operation discards all state; no partial strobes.
- FCW arithmetic: fcw_raw = NOM_FCW + (v_ctrl >>> GAIN_SH), evaluated in 34-bit signed. fcw_clamped = min(max(fcw_raw, FCW_MIN), FCW_MAX).
- FCW register update rule, by state:
  - IDLE: fcw <= NOM_FCW.
  - TRACK with ctrl_valid: fcw <= fcw_clamped. Latency is one cycle from the ctrl_valid edge to the fcw output; the new fcw first affects phase on the following cycle.
  - TRACK without ctrl_valid: fcw holds.
  - HOLDOVER: fcw holds the last TRACK value until ctrl_valid.
- Accumulator: every cycle, {carry, phase_next} = phase + fcw, modulo 2^PHASE_W.
  - sample_stb <= carry.
  - edge_stb <= (~phase[MSB] & phase_next[MSB]).
  - Both strobes are registered and align with the phase update.
  - FCW_MAX < half-scale guarantees at most one strobe per cycle and no double wrap.
- State machine:
  - IDLE -> TRACK on enable=1 and ctrl_valid=1; fcw loads fcw_clamped on that cycle.
  - TRACK: timeout counter clears on ctrl_valid, else increments. TRACK -> HOLDOVER when the counter reaches HOLD_TIMEOUT-1 and ctrl_valid=0.
  - HOLDOVER -> TRACK on ctrl_valid; fcw loads and the counter clears.
  - Any state -> IDLE on enable=0. Phase keeps running at NOM_FCW; the counter clears.
- Simultaneous events:
  - enable=0 beats ctrl_valid.
  - ctrl_valid beats timeout expiry on the same cycle, so the block stays in TRACK.
- holdover = (state==HOLDOVER), registered with state.
- X on v_ctrl while ctrl_valid=1 (simulation only): treat as no update; fcw holds.

Optional Feature:
- Macro: CDR_NCO_DITHER_EN.
- Defined:
  - A 16-bit maximal LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - Its low 4 bits, zero-extended, are added to fcw in the accumulator sum only. The fcw output is not dithered.
  - Purpose: breaks up spurs from a rational FCW.
- Undefined: no LFSR is instantiated and the accumulator uses fcw directly; behaviour is bit-exact as described above.

Decomposition:
- Shared package cdr_pkg holds:
  - the state encoding constants IDLE/TRACK/HOLDOVER;
  - PHASE_W default;
  - a clamp function for unsigned FCW bounds.
- Natural sub-module: cdr_nco_phase_acc, covering the accumulator, carry/MSB strobe generation and the optional dither LFSR. The top keeps the FSM and FCW computation.

Test Plan:
- Reset then enable=1, ctrl_valid=0 for 64 cycles:
  - state stays IDLE, fcw=32'h1000_0000;
  - sample_stb every 16 cycles, first at cycle 16;
  - edge_stb 8 cycles offset from sample_stb.
- enable=1, ctrl_valid=1, v_ctrl=32'sh0100_0000:
  - next cycle state=TRACK, fcw=32'h1001_0000;
  - strobe period shrinks and wraps drift earlier over 4096 cycles.
- v_ctrl=32'sh7FFF_FFFF, then v_ctrl=-32'sh8000_0000 with ctrl_valid:
  - fcw clamps to 32'h2000_0000, then 32'h0800_0000;
  - sample_stb periods 8 and 32.
- Track with one update, then ctrl_valid=0 for 1024 cycles:
  - state=HOLDOVER on the cycle after the 1024th, with fcw unchanged.
  - A ctrl_valid pulse returns state to TRACK and loads the new fcw.
  - Also drive ctrl_valid exactly on the expiry cycle: the block stays in TRACK.
- enable=0 together with ctrl_valid=1 while in TRACK:
  - state=IDLE, fcw=NOM_FCW next cycle, phase continues without reset.
  - Assert rst mid-run: all outputs at reset values the next cycle.
